dual_clock_counter_sync: RTL

Dual-domain counter pair with per-domain enable and direction, generalised in width and overflow mode. count2, which lives in the clk2 domain, is transferred into the clk1 domain through a Gray-coded multi-flop synchroniser. A clk1-domain difference output gives the modular distance between the two counters. It is used as a cross-domain event-rate monitor and as the team's CDC/STA exercise block.

---
 rtl/dual_clock_counter_sync.sv | 136 +++++++++++++
 1 files changed

// File: rtl/dual_clock_counter_sync.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : dual_clock_counter_sync
// Brief    : Up/down counters in two unrelated clock domains; the clk2 count is
//            carried into clk1 as Gray code and compared against count1.
// Revision : 1.0 - initial release
// ============================================================================
module dual_clock_counter_sync #(
  parameter int WIDTH       = 4,
  parameter int SYNC_STAGES = 2,
  parameter int SATURATE    = 0
) (
  input  logic             clk1,
  input  logic             clk2,
  input  logic             rst,
  input  logic             en1,
  input  logic             up1,
  input  logic             load1,
  input  logic [WIDTH-1:0] load_val1,
  input  logic             en2,
  input  logic             up2,
  output logic [WIDTH-1:0] count1,
  output logic [WIDTH-1:0] count2,
  output logic [WIDTH-1:0] count2_sync,
  output logic [WIDTH-1:0] delta,
  output logic             wrap1,
  output logic             wrap2
);

  localparam logic [WIDTH-1:0] c_max  = '1;
  localparam logic [WIDTH-1:0] c_zero = '0;
  localparam logic [WIDTH-1:0] c_one  = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam int               c_sync_bits = SYNC_STAGES * WIDTH;

  // Returns {limit_hit, next_count}; a hit is any enabled step past the range.
  function automatic logic [WIDTH:0] f_step(input logic [WIDTH-1:0] cur,
                                            input logic en, input logic up);
    logic [WIDTH:0] res;
    res = {1'b0, cur};
    if (en) begin
      if (up) begin
        if (cur == c_max) res = {1'b1, (SATURATE != 0) ? c_max : c_zero};
        else              res = {1'b0, cur + c_one};
      end else begin
        if (cur == c_zero) res = {1'b1, (SATURATE != 0) ? c_zero : c_max};
        else               res = {1'b0, cur - c_one};
      end
    end
    return res;
  endfunction

  function automatic logic [WIDTH-1:0] f_gray2bin(input logic [WIDTH-1:0] g);
    logic [WIDTH-1:0] b;
    b[WIDTH-1] = g[WIDTH-1];
    for (int i = WIDTH - 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  // clk1 counter
  logic [WIDTH-1:0] r_count1;
  logic [WIDTH-1:0] w_next1;
  logic             r_wrap1;
  logic             w_hit1;

  always_comb begin
    {w_hit1, w_next1} = f_step(r_count1, en1, up1);
    if (load1) begin
      w_next1 = load_val1;
      w_hit1  = 1'b0;
    end
  end

  always_ff @(posedge clk1 or posedge rst) begin
    if (rst) begin
      r_count1 <= '0;
      r_wrap1  <= 1'b0;
    end else begin
      r_count1 <= w_next1;
      r_wrap1  <= w_hit1;
    end
  end

  // clk2 counter; the Gray copy is registered from the same next value so it
  // changes on the same edge and by at most one bit.
  logic [WIDTH-1:0] r_count2;
  logic [WIDTH-1:0] w_next2;
  logic [WIDTH-1:0] r_gray2;
  logic             r_wrap2;
  logic             w_hit2;

  always_comb begin
    {w_hit2, w_next2} = f_step(r_count2, en2, up2);
  end

  always_ff @(posedge clk2 or posedge rst) begin
    if (rst) begin
      r_count2 <= '0;
      r_gray2  <= '0;
      r_wrap2  <= 1'b0;
    end else begin
      r_count2 <= w_next2;
      r_gray2  <= w_next2 ^ (w_next2 >> 1);
      r_wrap2  <= w_hit2;
    end
  end

  // clk1 synchroniser chain; stage 0 sits in the low WIDTH bits.
  logic [c_sync_bits-1:0] r_sync;
  logic [WIDTH-1:0]       w_sync_last;
  logic [WIDTH-1:0]       r_count2_sync;
  logic [WIDTH-1:0]       r_delta;

  assign w_sync_last = r_sync[c_sync_bits-1 -: WIDTH];

  always_ff @(posedge clk1 or posedge rst) begin
    if (rst) begin
      r_sync        <= '0;
      r_count2_sync <= '0;
      r_delta       <= '0;
    end else begin
      r_sync        <= {r_sync[c_sync_bits-WIDTH-1:0], r_gray2};
      r_count2_sync <= f_gray2bin(w_sync_last);
      r_delta       <= r_count1 - r_count2_sync;
    end
  end

  assign count1      = r_count1;
  assign count2      = r_count2;
  assign count2_sync = r_count2_sync;
  assign delta       = r_delta;
  assign wrap1       = r_wrap1;
  assign wrap2       = r_wrap2;

endmodule
`default_nettype wire
